iec_host_tx: RTL and testbench

- Host-side (C64-end) IEC serial-bus talker: sends one byte per handshake to listener drives such as c1541_drv.
- Optional ATN command framing, EOI signalling, frame acknowledge and device-not-present / frame-error timeouts.
- Sits in the host IEC glue in the clk domain; outputs are combined with other host drivers via the existing external open-collector OR.
- All timing counts ce ticks; ce is 1 MHz, so 1 tick = 1 us.

---
 rtl/iec_host_tx.sv | 163 ++++++++++++++++
 tb/tb_iec_host_tx.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iec_host_tx.sv
// Host-side IEC serial-bus talker: sends one byte per request, with optional ATN framing,
// EOI handshake, frame acknowledge and timeouts. All timing is in ce ticks (1 us).
module iec_host_tx #(
  parameter int T_PRESENT = 1000,
  parameter int T_SETUP   = 70,
  parameter int T_VALID   = 20,
  parameter int T_FRAME   = 1000,
  parameter int T_ATN_REL = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_atn,
  input  logic       tx_eoi,
  input  logic       atn_release,
  output logic       tx_ready,
  output logic       tx_done,
  output logic [1:0] tx_err,
  input  logic       iec_atn_i,
  input  logic       iec_clk_i,
  input  logic       iec_data_i,
  output logic       iec_atn_o,
  output logic       iec_clk_o,
  output logic       iec_data_o,
  output logic [3:0] fsm_state
);

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int T_MAX = imax(imax(imax(T_PRESENT, T_SETUP), imax(T_VALID, T_FRAME)), T_ATN_REL);
  localparam int CW    = $clog2(T_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ATN_WAIT, S_READY, S_EOI_LOW, S_EOI_HIGH,
    S_BIT_SETUP, S_BIT_VALID, S_ACK_WAIT, S_REL_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [7:0]    data_q;
  logic          eoi_q, rel_q;
  logic [2:0]    bit_idx;
  logic          atn_held, clk_held;
  logic          accept, finish, timed;
  logic [1:0]    finish_err;

  // The talker never needs to read back ATN or CLK; only DATA carries listener responses.
  logic unused_lines;
  assign unused_lines = iec_atn_i ^ iec_clk_i;

  assign fsm_state = state_q;

  // Handshake: a byte is taken on a ce cycle where tx_valid & tx_ready; tx_done is a
  // one-clk pulse and tx_err is meaningful only while tx_done is high.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      data_q   <= '0;
      eoi_q    <= 1'b0;
      rel_q    <= 1'b0;
      bit_idx  <= '0;
      atn_held <= 1'b0;
      clk_held <= 1'b0;
      tx_done  <= 1'b0;
      tx_err   <= 2'd0;
    end else begin
      state_q <= state_d;
      tx_done <= finish;
      tx_err  <= finish_err;
      if (state_d != state_q) cnt_q <= '0;
      else if (ce && timed)   cnt_q <= cnt_q + CW'(1);
      if (accept) begin
        data_q  <= tx_data;
        eoi_q   <= tx_eoi;
        rel_q   <= atn_release;
        bit_idx <= '0;
        if (tx_atn) atn_held <= 1'b1;
      end
      if (state_q == S_BIT_VALID && state_d == S_BIT_SETUP) bit_idx <= bit_idx + 3'd1;
      if (finish) begin
        if (finish_err == 2'd0) begin
          clk_held <= 1'b1;
        end else begin
          clk_held <= 1'b0;
          atn_held <= 1'b0;
        end
      end
      if (state_q == S_REL_WAIT && state_d == S_IDLE) begin
        clk_held <= 1'b0;
        atn_held <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    finish     = 1'b0;
    finish_err = 2'd0;
    timed      = state_q inside {S_ATN_WAIT, S_BIT_SETUP, S_BIT_VALID, S_ACK_WAIT, S_REL_WAIT};
    if (ce) begin
      unique case (state_q)
        S_IDLE: if (tx_valid) begin
          accept  = 1'b1;
          state_d = tx_atn ? S_ATN_WAIT : S_READY;
        end
        S_ATN_WAIT: begin
          if (!iec_data_i) begin
            state_d = S_READY;
          end else if (cnt_q == CW'(T_PRESENT - 1)) begin
            finish     = 1'b1;
            finish_err = 2'd1;
            state_d    = S_IDLE;
          end
        end
        S_READY:    if (iec_data_i)  state_d = eoi_q ? S_EOI_LOW : S_BIT_SETUP;
        S_EOI_LOW:  if (!iec_data_i) state_d = S_EOI_HIGH;
        S_EOI_HIGH: if (iec_data_i)  state_d = S_BIT_SETUP;
        S_BIT_SETUP: if (cnt_q == CW'(T_SETUP - 1)) state_d = S_BIT_VALID;
        S_BIT_VALID: if (cnt_q == CW'(T_VALID - 1))
          state_d = (bit_idx == 3'd7) ? S_ACK_WAIT : S_BIT_SETUP;
        S_ACK_WAIT: begin
          if (!iec_data_i) begin
            finish  = 1'b1;
            state_d = rel_q ? S_REL_WAIT : S_IDLE;
          end else if (cnt_q == CW'(T_FRAME - 1)) begin
            finish     = 1'b1;
            finish_err = 2'd2;
            state_d    = S_IDLE;
          end
        end
        S_REL_WAIT: if (cnt_q == CW'(T_ATN_REL - 1)) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Line drive is a pure function of state; ATN and the idle CLK hold persist across bytes.
  always_comb begin
    tx_ready   = (state_q == S_IDLE);
    iec_atn_o  = atn_held;
    iec_clk_o  = 1'b0;
    iec_data_o = 1'b0;
    unique case (state_q)
      S_IDLE:      iec_clk_o = clk_held;
      S_ATN_WAIT,
      S_ACK_WAIT,
      S_REL_WAIT:  iec_clk_o = 1'b1;
      S_BIT_SETUP: begin
        iec_clk_o  = 1'b1;
        iec_data_o = ~data_q[bit_idx];
      end
      S_BIT_VALID: iec_data_o = ~data_q[bit_idx];
      default:     iec_clk_o = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_iec_host_tx.sv
// Directed bench for iec_host_tx: a small listener model on DATA plus a line monitor
// that records CLK release intervals, tx_done pulses and ATN edges in ce ticks.
module tb_iec_host_tx;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ce = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0, tx_atn = 1'b0, tx_eoi = 1'b0, atn_release = 1'b0;
  logic       tx_ready, tx_done;
  logic [1:0] tx_err;
  logic       iec_atn_i, iec_clk_i, iec_data_i;
  logic       iec_atn_o, iec_clk_o, iec_data_o;
  logic [3:0] fsm_state;
  logic       lst_data = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  assign iec_atn_i  = ~iec_atn_o;
  assign iec_clk_i  = ~iec_clk_o;
  assign iec_data_i = ~(iec_data_o | lst_data);

  iec_host_tx dut (
    .clk(clk), .reset_n(reset_n), .ce(ce),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_atn(tx_atn), .tx_eoi(tx_eoi),
    .atn_release(atn_release), .tx_ready(tx_ready), .tx_done(tx_done), .tx_err(tx_err),
    .iec_atn_i(iec_atn_i), .iec_clk_i(iec_clk_i), .iec_data_i(iec_data_i),
    .iec_atn_o(iec_atn_o), .iec_clk_o(iec_clk_o), .iec_data_o(iec_data_o),
    .fsm_state(fsm_state)
  );

  // clock / ce / tick
  always #5 clk = ~clk;
  initial forever begin
    @(negedge clk);
    ce = ~ce;
  end
  int tick = 0;
  always @(posedge clk) if (ce) tick <= tick + 1;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // line monitor
  logic mon_clear = 1'b0, atn_watch = 1'b0;
  logic prev_clk = 1'b0, prev_atn = 1'b0, in_rel = 1'b0, cur_bit = 1'b0;
  logic atn_gap = 1'b0, atn_seen = 1'b0, atn_rel_seen = 1'b0;
  logic [1:0] last_err = 2'd0;
  int n_rel = 0, n_done = 0, done_tick = 0, atn_rel_tick = 0, cur_start = 0;
  int rel_start[16];
  int rel_width[16];
  logic rel_bit[16];

  always @(negedge clk) begin
    prev_clk <= iec_clk_o;
    prev_atn <= iec_atn_o;
    if (mon_clear) begin
      n_rel <= 0; n_done <= 0; in_rel <= 1'b0;
      atn_gap <= 1'b0; atn_seen <= 1'b0; atn_rel_seen <= 1'b0;
    end else begin
      if (prev_clk && !iec_clk_o) begin
        in_rel <= 1'b1; cur_start <= tick; cur_bit <= iec_data_i;
      end
      if (!prev_clk && iec_clk_o && in_rel && n_rel < 16) begin
        rel_start[n_rel] <= cur_start;
        rel_width[n_rel] <= tick - cur_start;
        rel_bit[n_rel]   <= cur_bit;
        n_rel  <= n_rel + 1;
        in_rel <= 1'b0;
      end
      if (tx_done) begin
        n_done <= n_done + 1; last_err <= tx_err; done_tick <= tick;
      end
      if (atn_watch && !iec_atn_o) atn_gap <= 1'b1;
      if (iec_atn_o) atn_seen <= 1'b1;
      if (prev_atn && !iec_atn_o && !atn_rel_seen) begin
        atn_rel_seen <= 1'b1; atn_rel_tick <= tick;
      end
    end
  end

  // driver tasks
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!ce) @(posedge clk);
    end
    #1;
  endtask

  task automatic clear_mon();
    mon_clear = 1'b1;
    @(negedge clk);
    #1 mon_clear = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; tx_valid = 1'b0; lst_data = 1'b0; atn_watch = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b1;
    clear_mon();
  endtask

  task automatic send(input logic [7:0] d, input logic a, input logic e, input logic r,
                      output int acc);
    tx_data = d; tx_atn = a; tx_eoi = e; atn_release = r; tx_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!tx_ready) break;
    end
    tx_valid = 1'b0;
    acc = tick;
    n_checks++;
    if (tx_ready !== 1'b0) begin
      n_fail++; $display("FAIL accept: tx_ready %b, required 0", tx_ready);
    end
  endtask

  task automatic wait_rel(input int target, input int budget, input string name);
    for (int i = 0; i < budget && n_rel < target; i++) wait_ticks(1);
    n_checks++;
    if (n_rel < target) begin
      n_fail++; $display("FAIL %s: clk release pulses %0d, required %0d", name, n_rel, target);
    end
  endtask

  task automatic wait_done(input int budget, input string name);
    for (int i = 0; i < budget && n_done == 0; i++) wait_ticks(1);
    n_checks++;
    if (n_done == 0) begin
      n_fail++; $display("FAIL %s: no tx_done within %0d ticks", name, budget);
    end
  endtask

  // tests
  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({tx_ready, tx_done, tx_err} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_status: got %b, required 1000", {tx_ready, tx_done, tx_err});
    end
    n_checks++;
    if ({iec_atn_o, iec_clk_o, iec_data_o} !== 3'b000) begin
      n_fail++; $display("FAIL reset_lines: got %b, required 000", {iec_atn_o, iec_clk_o, iec_data_o});
    end
  endtask

  task automatic test_atn_byte();
    int acc;
    logic [7:0] exp;
    exp = 8'h28;
    do_reset();
    send(8'h28, 1'b1, 1'b0, 1'b0, acc);
    atn_watch = 1'b1;
    wait_ticks(50); lst_data = 1'b1;
    wait_ticks(50); lst_data = 1'b0;
    wait_rel(9, 1000, "atn_bits");
    wait_ticks(10); lst_data = 1'b1;
    wait_done(200, "atn_done");
    atn_watch = 1'b0;
    n_checks++;
    if (n_rel !== 9) begin n_fail++; $display("FAIL atn_pulses: got %0d, required 9", n_rel); end
    n_checks++;
    if (n_done !== 1 || last_err !== 2'd0) begin
      n_fail++; $display("FAIL atn_result: done %0d err %0d, required 1 and 0", n_done, last_err);
    end
    n_checks++;
    if (atn_gap !== 1'b0) begin n_fail++; $display("FAIL atn_held: ATN dropped, required held"); end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (rel_bit[1+i] !== exp[i]) begin
        n_fail++; $display("FAIL atn_bit%0d: got %b, required %b", i, rel_bit[1+i], exp[i]);
      end
      n_checks++;
      if (rel_width[1+i] !== 20) begin
        n_fail++; $display("FAIL atn_width%0d: got %0d, required 20", i, rel_width[1+i]);
      end
      if (i < 7) begin
        n_checks++;
        if (rel_start[2+i] - rel_start[1+i] !== 90) begin
          n_fail++; $display("FAIL atn_period%0d: got %0d, required 90", i, rel_start[2+i] - rel_start[1+i]);
        end
      end
    end
    n_checks++;
    if ({iec_atn_o, iec_clk_o, iec_data_o, tx_ready} !== 4'b1101) begin
      n_fail++; $display("FAIL atn_after: got %b, required 1101", {iec_atn_o, iec_clk_o, iec_data_o, tx_ready});
    end
  endtask

  task automatic test_no_device();
    int acc;
    do_reset();
    send(8'h48, 1'b1, 1'b0, 1'b0, acc);
    wait_done(1100, "nodev_done");
    n_checks++;
    if (last_err !== 2'd1) begin n_fail++; $display("FAIL nodev_err: got %0d, required 1", last_err); end
    n_checks++;
    if (done_tick - acc !== 1000) begin
      n_fail++; $display("FAIL nodev_time: got %0d ticks, required 1000", done_tick - acc);
    end
    n_checks++;
    if ({iec_atn_o, iec_clk_o, iec_data_o, tx_ready} !== 4'b0001) begin
      n_fail++; $display("FAIL nodev_lines: got %b, required 0001", {iec_atn_o, iec_clk_o, iec_data_o, tx_ready});
    end
  endtask

  task automatic test_eoi();
    int acc, p_end;
    logic [7:0] exp;
    exp = 8'h55;
    do_reset();
    send(8'h55, 1'b0, 1'b1, 1'b0, acc);
    wait_ticks(200); lst_data = 1'b1;
    wait_ticks(60);  lst_data = 1'b0;
    p_end = tick;
    n_checks++;
    if (n_rel !== 0) begin n_fail++; $display("FAIL eoi_early: got %0d pulses, required 0", n_rel); end
    wait_rel(8, 1000, "eoi_bits");
    wait_ticks(10); lst_data = 1'b1;
    wait_done(200, "eoi_done");
    n_checks++;
    if (rel_start[0] !== p_end + 71) begin
      n_fail++; $display("FAIL eoi_first_bit: got tick %0d, required %0d", rel_start[0], p_end + 71);
    end
    n_checks++;
    if (n_rel !== 8 || last_err !== 2'd0) begin
      n_fail++; $display("FAIL eoi_result: pulses %0d err %0d, required 8 and 0", n_rel, last_err);
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (rel_bit[i] !== exp[i]) begin
        n_fail++; $display("FAIL eoi_bit%0d: got %b, required %b", i, rel_bit[i], exp[i]);
      end
    end
  endtask

  task automatic test_no_ack();
    int acc, ack_start;
    logic [7:0] exp;
    exp = 8'hA3;
    do_reset();
    send(8'hA3, 1'b0, 1'b0, 1'b0, acc);
    wait_rel(8, 1000, "noack_bits");
    wait_done(1100, "noack_done");
    ack_start = rel_start[7] + rel_width[7];
    n_checks++;
    if (last_err !== 2'd2) begin n_fail++; $display("FAIL noack_err: got %0d, required 2", last_err); end
    n_checks++;
    if (done_tick - ack_start !== 1000) begin
      n_fail++; $display("FAIL noack_time: got %0d ticks, required 1000", done_tick - ack_start);
    end
    n_checks++;
    if ({iec_atn_o, iec_clk_o, iec_data_o, tx_ready} !== 4'b0001) begin
      n_fail++; $display("FAIL noack_lines: got %b, required 0001", {iec_atn_o, iec_clk_o, iec_data_o, tx_ready});
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (rel_bit[i] !== exp[i]) begin
        n_fail++; $display("FAIL noack_bit%0d: got %b, required %b", i, rel_bit[i], exp[i]);
      end
    end
  endtask

  task automatic test_atn_release();
    int acc, d1;
    logic [7:0] exp;
    exp = 8'h11;
    do_reset();
    send(8'h3F, 1'b1, 1'b0, 1'b1, acc);
    wait_ticks(50); lst_data = 1'b1;
    wait_ticks(50); lst_data = 1'b0;
    wait_rel(9, 1000, "rel_bits");
    wait_ticks(10); lst_data = 1'b1;
    wait_done(200, "rel_done");
    d1 = done_tick;
    n_checks++;
    if (last_err !== 2'd0 || iec_atn_o !== 1'b1) begin
      n_fail++; $display("FAIL rel_ack: err %0d atn %b, required 0 and 1", last_err, iec_atn_o);
    end
    for (int i = 0; i < 100 && !atn_rel_seen; i++) wait_ticks(1);
    n_checks++;
    if (atn_rel_seen !== 1'b1 || atn_rel_tick - d1 !== 20) begin
      n_fail++; $display("FAIL rel_time: seen %b after %0d ticks, required 1 after 20", atn_rel_seen, atn_rel_tick - d1);
    end
    n_checks++;
    if ({iec_clk_o, tx_ready} !== 2'b01) begin
      n_fail++; $display("FAIL rel_lines: got %b, required 01", {iec_clk_o, tx_ready});
    end
    wait_ticks(10); lst_data = 1'b0;
    clear_mon();
    send(8'h11, 1'b0, 1'b0, 1'b0, acc);
    wait_rel(8, 1000, "rel_next_bits");
    wait_ticks(10); lst_data = 1'b1;
    wait_done(200, "rel_next_done");
    n_checks++;
    if (atn_seen !== 1'b0 || last_err !== 2'd0) begin
      n_fail++; $display("FAIL rel_next: atn_seen %b err %0d, required 0 and 0", atn_seen, last_err);
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (rel_bit[i] !== exp[i]) begin
        n_fail++; $display("FAIL rel_next_bit%0d: got %b, required %b", i, rel_bit[i], exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int acc;
    do_reset();
    send(8'h07, 1'b0, 1'b0, 1'b0, acc);
    wait_rel(3, 800, "mid_bits");
    wait_ticks(10);
    n_checks++;
    if ({iec_clk_o, iec_data_o} !== 2'b11) begin
      n_fail++; $display("FAIL mid_setup3: got %b, required 11", {iec_clk_o, iec_data_o});
    end
    reset_n = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({iec_atn_o, iec_clk_o, iec_data_o, tx_ready, tx_done} !== 5'b00010) begin
      n_fail++; $display("FAIL mid_reset: got %b, required 00010", {iec_atn_o, iec_clk_o, iec_data_o, tx_ready, tx_done});
    end
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b1;
    wait_ticks(20);
    n_checks++;
    if (n_done !== 0) begin n_fail++; $display("FAIL mid_no_done: got %0d pulses, required 0", n_done); end
  endtask

  initial begin
    test_reset();
    test_atn_byte();
    test_no_device();
    test_eoi();
    test_no_ack();
    test_atn_release();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
